// File: rtl/uart.sv
// Byte-oriented UART: transmitter with busy handshake, receiver with start-bit
// glitch rejection and framing check, and a first-word-fall-through receive FIFO
// with sticky overrun/framing flags.
module uart #(
  parameter int unsigned DIVISOR    = 217,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic                  tx,
  input  logic [7:0]            tx_data,
  input  logic                  tx_we,
  output logic                  tx_busy,
  output logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  rx_rd,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  err_ovr,
  output logic                  err_frm,
  input  logic                  err_clr
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] HALF_LAST = 16'(DIVISOR / 2 - 1);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;

  // TX state register; the line output and busy flag are registered with it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // TX next state: each symbol is held for DIVISOR cycles by a down-counter
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (tx_we) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_cnt_d   = BIT_LAST;
          tx_d       = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = 3'd0;
          tx_d       = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = TX_IDLE;
          tx_d       = 1'b1;
          tx_busy_d  = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = tx_busy_q;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall_c;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall_c = rx_prev_q & ~rx_sync_q;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_push_c;
  logic        frm_set_c;

  // RX state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  // RX next state: mid-bit sampling; BREAK waits out a low stop bit before re-arming
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_push_c  = 1'b0;
    frm_set_c  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall_c) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_sync_q) begin
            rx_push_c  = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frm_set_c  = 1'b1;
            rx_state_d = RX_BREAK;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_BREAK: begin
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO and sticky flags
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q [DEPTH];
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  cnt_t       count_q, count_d;
  logic [7:0] head_q, head_d;
  logic       ready_q, ready_d;
  logic       err_ovr_q, err_ovr_d;
  logic       err_frm_q, err_frm_d;
  logic       full_c, pop_ok_c, push_ok_c, ovr_set_c;

  // FIFO bookkeeping; a pop frees a slot for a same-cycle push even when full
  always_comb begin
    full_c    = (count_q == cnt_t'(DEPTH));
    pop_ok_c  = rx_rd && (count_q != '0);
    push_ok_c = rx_push_c && (!full_c || pop_ok_c);
    ovr_set_c = rx_push_c && full_c && !pop_ok_c;

    wr_ptr_d = push_ok_c ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok_c  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    count_d  = count_q + cnt_t'(push_ok_c) - cnt_t'(pop_ok_c);

    head_d = 8'h00;
    if (count_d != '0) begin
      if (push_ok_c && (rd_ptr_d == wr_ptr_q)) begin
        head_d = rx_shift_q;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
    ready_d = (count_d != '0);

    err_ovr_d = ovr_set_c | (err_ovr_q & ~err_clr);
    err_frm_d = frm_set_c | (err_frm_q & ~err_clr);
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clock) begin
    if (reset_n && push_ok_c) begin
      mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  // FIFO pointers, registered head/ready/count and sticky flags
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      head_q    <= 8'h00;
      ready_q   <= 1'b0;
      err_ovr_q <= 1'b0;
      err_frm_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      ready_q   <= ready_d;
      err_ovr_q <= err_ovr_d;
      err_frm_q <= err_frm_d;
    end
  end

  assign rx_data  = head_q;
  assign rx_ready = ready_q;
  assign rx_count = count_q;
  assign err_ovr  = err_ovr_q;
  assign err_frm  = err_frm_q;

endmodule

// File: tb/tb_uart.sv
// Directed testbench for uart: TX framing, loopback, glitch/framing errors,
// FIFO overrun, mid-frame reset and receive baud tolerance.
module tb_uart;

  localparam int unsigned D     = 8;
  localparam int unsigned D2    = 217;
  // Stop sample falls 9.5 bit periods plus the 2-cycle synchronizer after the line drops
  localparam int          RD_AT = (19 * D) / 2 + 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_drv, rx2_drv, loop;
  logic       rx_line;
  logic       tx, tx_busy, rx_ready, err_ovr, err_frm;
  logic [7:0] tx_data, rx_data;
  logic       tx_we, rx_rd, err_clr;
  logic [3:0] rx_count;

  logic       tx2, tx2_busy, rx2_ready, err2_ovr, err2_frm;
  logic [7:0] tx2_data, rx2_data;
  logic       tx2_we, rx2_rd, err2_clr;
  logic [3:0] rx2_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rx_line = loop ? tx : rx_drv;

  uart #(.DIVISOR(D), .DEPTH_LOG2(3)) dut (
    .clock(clk), .reset_n(reset_n), .rx(rx_line), .tx(tx),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_rd(rx_rd), .rx_count(rx_count),
    .err_ovr(err_ovr), .err_frm(err_frm), .err_clr(err_clr)
  );

  uart #(.DIVISOR(D2), .DEPTH_LOG2(3)) dut2 (
    .clock(clk), .reset_n(reset_n), .rx(rx2_drv), .tx(tx2),
    .tx_data(tx2_data), .tx_we(tx2_we), .tx_busy(tx2_busy),
    .rx_data(rx2_data), .rx_ready(rx2_ready), .rx_rd(rx2_rd), .rx_count(rx2_count),
    .err_ovr(err2_ovr), .err_frm(err2_frm), .err_clr(err2_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx2_drv = v;
    else     rx_drv  = v;
  endtask

  // Drive one serial frame of per cycles per symbol; optional pop strobe at rd_at,
  // optional early abort at stop_at (line left at its current level)
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int per,
                             input bit sel, input int rd_at, input int stop_at);
    logic [9:0] sym;
    sym = {stop, b, 1'b0};
    for (int c = 0; c < 10 * per; c++) begin
      if (c == stop_at) return;
      set_line(sel, sym[c / per]);
      rx_rd = (c == rd_at);
      tick();
    end
    rx_rd = 1'b0;
    set_line(sel, 1'b1);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while (tx_busy && n < 200) begin
      tick();
      n++;
    end
    chk("tx_busy timeout", 32'(tx_busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] txb;
    logic [7:0] bs [3];
    logic       exp_tx;
    logic       exp_busy;
    int         n;

    reset_n = 1'b0; rx_drv = 1'b1; rx2_drv = 1'b1; loop = 1'b0;
    tx_data = 8'h00; tx_we = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
    tx2_data = 8'h00; tx2_we = 1'b0; rx2_rd = 1'b0; err2_clr = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("reset tx", 32'(tx), 1);
    chk("reset tx_busy", 32'(tx_busy), 0);
    chk("reset rx_ready", 32'(rx_ready), 0);
    chk("reset rx_count", 32'(rx_count), 0);
    chk("reset rx_data", 32'(rx_data), 0);
    chk("reset err_ovr", 32'(err_ovr), 0);
    chk("reset err_frm", 32'(err_frm), 0);
    chk("reset tx2", 32'(tx2), 1);
    reset_n = 1'b1;
    repeat (2) tick();

    // TX single byte A5, with an ignored write at cycle 40
    txb = 8'hA5;
    tx_data = txb; tx_we = 1'b1;
    tick();
    tx_we = 1'b0;
    for (int c = 1; c <= 88; c++) begin
      if (c <= 8)       exp_tx = 1'b0;
      else if (c <= 72) exp_tx = txb[(c - 9) / 8];
      else              exp_tx = 1'b1;
      exp_busy = (c <= 80);
      chk("tx line", 32'(tx), 32'(exp_tx));
      chk("tx_busy", 32'(tx_busy), 32'(exp_busy));
      if (c == 40) begin
        tx_data = 8'h0F; tx_we = 1'b1;
      end else begin
        tx_we = 1'b0;
      end
      tick();
    end

    // Loopback of three back-to-back frames
    loop = 1'b1;
    bs[0] = 8'h00; bs[1] = 8'hFF; bs[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      wait_tx_idle();
      tx_data = bs[i]; tx_we = 1'b1;
      tick();
      tx_we = 1'b0;
    end
    n = 0;
    while (rx_count != 4'd3 && n < 300) begin
      tick();
      n++;
    end
    chk("loop rx_count", 32'(rx_count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("loop rx_ready", 32'(rx_ready), 1);
      chk("loop rx_data", 32'(rx_data), 32'(bs[i]));
      pop();
    end
    chk("loop empty rx_ready", 32'(rx_ready), 0);
    chk("loop empty rx_data", 32'(rx_data), 0);
    chk("loop empty rx_count", 32'(rx_count), 0);
    wait_tx_idle();
    loop = 1'b0;
    repeat (4) tick();

    // Glitch rejection
    rx_drv = 1'b0;
    repeat (2) tick();
    rx_drv = 1'b1;
    repeat (30) tick();
    chk("glitch rx_count", 32'(rx_count), 0);
    chk("glitch err_frm", 32'(err_frm), 0);
    chk("glitch err_ovr", 32'(err_ovr), 0);

    // Framing error and clear
    drive_frame(8'h12, 1'b0, D, 1'b0, -1, -1);
    repeat (10) tick();
    chk("frm err_frm", 32'(err_frm), 1);
    chk("frm rx_count", 32'(rx_count), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("frm cleared", 32'(err_frm), 0);

    // Overrun: nine frames with no pops
    for (int i = 0; i < 9; i++) begin
      drive_frame(8'h40 + 8'(i), 1'b1, D, 1'b0, -1, -1);
      repeat (4) tick();
    end
    chk("ovr rx_count", 32'(rx_count), 8);
    chk("ovr err_ovr", 32'(err_ovr), 1);
    chk("ovr head", 32'(rx_data), 32'h40);
    // Tenth frame pushes in the same cycle as a pop
    drive_frame(8'h49, 1'b1, D, 1'b0, RD_AT, -1);
    repeat (4) tick();
    chk("ovr10 rx_count", 32'(rx_count), 8);
    chk("ovr10 head", 32'(rx_data), 32'h41);
    for (int i = 0; i < 8; i++) begin
      chk("ovr drain", 32'(rx_data), (i < 7) ? 32'h41 + 32'(i) : 32'h49);
      pop();
    end
    chk("ovr drained count", 32'(rx_count), 0);
    chk("ovr still sticky", 32'(err_ovr), 1);

    // Mid-frame reset during TX data bit 3
    drive_frame(8'h5A, 1'b1, D, 1'b0, -1, -1);
    drive_frame(8'h33, 1'b0, D, 1'b0, -1, -1);
    repeat (10) tick();
    chk("pre-rst count", 32'(rx_count), 1);
    chk("pre-rst err_frm", 32'(err_frm), 1);
    tx_data = 8'hC3; tx_we = 1'b1;
    tick();
    tx_we = 1'b0;
    repeat (35) tick();
    chk("tx bit3 before reset", 32'(tx), 0);
    chk("tx busy before reset", 32'(tx_busy), 1);
    reset_n = 1'b0;
    tick();
    chk("txrst tx", 32'(tx), 1);
    chk("txrst tx_busy", 32'(tx_busy), 0);
    chk("txrst rx_count", 32'(rx_count), 0);
    chk("txrst err_ovr", 32'(err_ovr), 0);
    chk("txrst err_frm", 32'(err_frm), 0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Mid-frame reset during RX data bit 5
    drive_frame(8'h77, 1'b1, D, 1'b0, -1, -1);
    repeat (4) tick();
    chk("pre-rxrst count", 32'(rx_count), 1);
    drive_frame(8'h99, 1'b1, D, 1'b0, -1, 52);
    reset_n = 1'b0; rx_drv = 1'b1;
    tick();
    chk("rxrst rx_count", 32'(rx_count), 0);
    chk("rxrst rx_ready", 32'(rx_ready), 0);
    chk("rxrst rx_data", 32'(rx_data), 0);
    reset_n = 1'b1;
    repeat (4) tick();
    drive_frame(8'h96, 1'b1, D, 1'b0, -1, -1);
    repeat (4) tick();
    chk("post-rst rx_count", 32'(rx_count), 1);
    chk("post-rst rx_data", 32'(rx_data), 32'h96);
    chk("post-rst err_frm", 32'(err_frm), 0);

    // Baud tolerance on the DIVISOR=217 instance: +2.8 % and -2.8 %
    drive_frame(8'hA7, 1'b1, 223, 1'b1, -1, -1);
    repeat (20) tick();
    drive_frame(8'h58, 1'b1, 211, 1'b1, -1, -1);
    repeat (20) tick();
    chk("slow rx2_count", 32'(rx2_count), 2);
    chk("slow rx2_data", 32'(rx2_data), 32'hA7);
    chk("rate err2_frm", 32'(err2_frm), 0);
    rx2_rd = 1'b1;
    tick();
    rx2_rd = 1'b0;
    chk("fast rx2_data", 32'(rx2_data), 32'h58);
    chk("fast rx2_ready", 32'(rx2_ready), 1);
    chk("rate err2_ovr", 32'(err2_ovr), 0);
    chk("rate tx2 idle", 32'(tx2), 1);
    chk("rate tx2_busy", 32'(tx2_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart.md
# uart

Byte-oriented asynchronous serial port for the AVR board top level. It drives the unused `RX`/`TX` pins and presents a simple register-style interface to the `io` block, which maps it into the processor's port space. The block contains:
- a transmitter with a busy handshake;
- a receiver with start-bit glitch rejection and framing check;
- an 8-entry first-word-fall-through receive FIFO with sticky error flags.

## Interface
Parameters:
- `DIVISOR`, 217, clock cycles per bit; 217 gives 115200 baud at 25 MHz. Legal range is 4..65535.
- `DEPTH_LOG2`, 3, log2 of the receive FIFO depth (8 entries).

Ports:
- `clock`  in  1  system clock (`clock_25` domain); all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `rx`  in  1  serial input pin, asynchronous; idles high.
- `tx`  out  1  serial output pin; idles high.
- `tx_data`  in  8  byte to send.
- `tx_we`  in  1  one-cycle write strobe for `tx_data`.
- `tx_busy`  out  1  transmitter occupied.
- `rx_data`  out  8  head of the receive FIFO; 8'h00 when the FIFO is empty.
- `rx_ready`  out  1  receive FIFO non-empty.
- `rx_rd`  in  1  one-cycle pop strobe.
- `rx_count`  out  DEPTH_LOG2+1  number of entries held.
- `err_ovr`  out  1  sticky overrun flag.
- `err_frm`  out  1  sticky framing-error flag.
- `err_clr`  in  1  clears both sticky flags.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `rx_ready`=0, `rx_count`=0, `rx_data`=8'h00, `err_ovr`=0, `err_frm`=0. Both FSMs go to IDLE, the FIFO pointers go to 0, and the synchronizer is preset to 1.
- Reset asserted mid-frame aborts both directions immediately. `tx` returns high on the next edge. A partial RX byte is discarded.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - In IDLE, `tx_we`=1 latches `tx_data` and moves to START.
  - `tx_we` is ignored while `tx_busy`=1.
  - Data bits are sent LSB first. The stop bit is a 1.
  - Each state holds for DIVISOR cycles, counted by a 16-bit down-counter.
- RX input path: `rx` passes through a 2-flop synchronizer. A falling edge of the synchronized signal is detected only in IDLE.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - START waits DIVISOR/2 cycles (integer division), then samples. If the sample is 1, it is treated as a glitch: return to IDLE with no flag set.
  - DATA takes 8 samples, each DIVISOR cycles apart. Bits shift in LSB first.
  - STOP samples once, DIVISOR cycles after the last data bit.
  - If the stop sample is 1, push the byte.
  - If the stop sample is 0, discard the byte and set `err_frm`. The FSM then waits for the synchronized line to read 1 before re-arming IDLE.
- FIFO:
  - Holds 2^DEPTH_LOG2 entries with circular pointers that wrap modulo depth. `rx_count` distinguishes full from empty.
  - `rx_rd` while empty is ignored.
  - A push while full with no simultaneous pop drops the byte and sets `err_ovr`.
  - A push and pop in the same cycle while full both succeed; the count is unchanged.
  - A push and pop in the same cycle while empty: the push succeeds and the pop is ignored.
- Flags: `err_clr` clears both flags. A set event in the same cycle as `err_clr` wins, so the flag ends up set.

## Timing
- TX, with the `tx_we` edge at cycle 0:
  - `tx_busy`=1 and `tx`=0 from cycle 1.
  - Data bit i drives from cycle 1+(i+1)·DIVISOR.
  - Stop bit drives from cycle 1+9·DIVISOR.
  - `tx_busy`=0 at cycle 1+10·DIVISOR. A new `tx_we` is accepted in that same cycle, giving back-to-back frames with no idle gap.
- RX:
  - Synchronizer latency is 2 cycles.
  - The stop-bit sample is taken about 9.5·DIVISOR cycles after the line falls.
  - The pushed byte appears on `rx_data`/`rx_ready` one cycle after the stop sample.
- FIFO pop: after an `rx_rd` edge, `rx_data` shows the next entry in the following cycle, and `rx_count` decrements in that same cycle.
- Baud tolerance: a frame must be received correctly with the remote bit period within ±3 % of DIVISOR.

## Test plan
Bench uses DIVISOR=8 and DEPTH_LOG2=3 unless noted.
- TX single byte: `tx_we` with 8'hA5 at cycle 0.
  - `tx` must read 0 (start) for cycles 1–8, then bits 1,0,1,0,0,1,0,1 at 8 cycles each, then 1 (stop).
  - `tx_busy` must be high for exactly cycles 1–80.
  - A second `tx_we` at cycle 40 must be ignored.
- Loopback: `tx` tied to `rx`, send 8'h00, 8'hFF, 8'h3C back-to-back. `rx_count` must reach 3. Popping must yield the same three bytes in order, after which `rx_ready`=0 and `rx_data`=8'h00.
- Glitch and framing:
  - A 2-cycle low pulse on `rx` must leave `rx_count`=0 and no flags set.
  - A frame 8'h12 with stop bit 0 must set `err_frm`=1 and `rx_count`=0.
  - `err_clr` must then return `err_frm` to 0.
- Overrun: inject 9 frames with no pops. `rx_count`=8 and `err_ovr`=1, and the head byte must be the first frame.
  - A 10th frame whose push coincides with `rx_rd` must be stored with `rx_count` remaining 8.
- Reset mid-operation: assert `reset_n`=0 during TX data bit 3 and during RX data bit 5.
  - On the next edge: `tx`=1, `tx_busy`=0, `rx_count`=0, flags 0.
  - The next full RX frame after release must be received correctly.
- Rate tolerance: RX frames driven at 1.03× and 0.97× the bit period with DIVISOR=217 must both be received correctly.
